// File: rtl/placement_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : placement_pkg                                              |
// | Shared widths, FSM state encoding and request/response structures    |
// | for the multi-program placement pipeline (row finder -> allocator).  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package placement_pkg;

  localparam int ROW_ID_W = 4;
  localparam int COL_W    = 5;
  localparam logic [ROW_ID_W-1:0] ROW_NONE = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } alloc_state_e;

  // Request as handed over by the row finder: width plus best-first candidates.
  typedef struct packed {
    logic [COL_W-1:0]    width;
    logic [ROW_ID_W-1:0] cand_1;
    logic [ROW_ID_W-1:0] cand_2;
    logic [ROW_ID_W-1:0] cand_3;
  } alloc_req_t;

  // Allocation result: row and starting column are zero on a failed grant.
  typedef struct packed {
    logic                ok;
    logic [ROW_ID_W-1:0] row;
    logic [COL_W-1:0]    x;
  } alloc_rsp_t;

endpackage
`default_nettype wire

// File: rtl/row_allocator_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : row_allocator_if                                         |
// | Request, response, row-clear and status signals of row_allocator.    |
// |   master : request producer / response consumer / clear source       |
// |   slave  : the allocator                                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface row_allocator_if;
  import placement_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [COL_W-1:0]    req_width;
  logic [ROW_ID_W-1:0] cand_id_1;
  logic [ROW_ID_W-1:0] cand_id_2;
  logic [ROW_ID_W-1:0] cand_id_3;
  logic                resp_valid;
  logic                resp_ready;
  logic                resp_ok;
  logic [ROW_ID_W-1:0] resp_row;
  logic [COL_W-1:0]    resp_x;
  logic                clr_valid;
  logic [ROW_ID_W-1:0] clr_row;
  logic                busy;

  modport master (
    output req_valid, req_width, cand_id_1, cand_id_2, cand_id_3,
    output resp_ready, clr_valid, clr_row,
    input  req_ready, resp_valid, resp_ok, resp_row, resp_x, busy
  );

  modport slave (
    input  req_valid, req_width, cand_id_1, cand_id_2, cand_id_3,
    input  resp_ready, clr_valid, clr_row,
    output req_ready, resp_valid, resp_ok, resp_row, resp_x, busy
  );

endinterface
`default_nettype wire

// File: rtl/row_allocator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : row_allocator                                               |
// | Probes up to three candidate rows in order and grants the first one  |
// | with enough free columns, using a bump pointer per row. Rows are     |
// | released whole through the clear port.                              |
// |   clk, rst_n : clock, asynchronous active-low reset                  |
// |   io (slave) : req_* in, resp_* out, clr_* in, busy out              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module row_allocator
  import placement_pkg::*;
#(
  parameter int NUM_ROWS  = 13,
  parameter int ROW_WIDTH = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  row_allocator_if.slave   io
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_CHECK = CHECK;
  localparam logic [1:0] S_RESP  = RESP;

  localparam logic [COL_W:0]    C_ROW_WIDTH = (COL_W+1)'(ROW_WIDTH);
  localparam logic [ROW_ID_W-1:0] C_MAX_ID  = ROW_ID_W'(NUM_ROWS);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  alloc_req_t       r_req;
  logic [1:0]       r_idx;
  alloc_rsp_t       r_rsp;
  logic             r_resp_valid;
  logic             r_req_ready;
  logic             r_busy;
  logic [COL_W-1:0] r_used [1:NUM_ROWS];

  logic                w_accept;
  logic                w_width_bad;
  logic [ROW_ID_W-1:0] w_cand;
  logic                w_cand_valid;
  logic [COL_W-1:0]    w_used_cur;
  logic [COL_W:0]      w_sum;
  logic                w_fits;
  logic                w_clr_hit;
  logic                w_probe;
  logic                w_stall;
  logic                w_grant;
  logic                w_fail;
  logic                w_resp_done;

  always_comb begin
    w_accept    = (r_state == S_IDLE) && r_req_ready && io.req_valid;
    w_width_bad = (io.req_width == '0) || ({1'b0, io.req_width} > C_ROW_WIDTH);

    case (r_idx)
      2'd0:    w_cand = r_req.cand_1;
      2'd1:    w_cand = r_req.cand_2;
      default: w_cand = r_req.cand_3;
    endcase
    w_cand_valid = (w_cand != ROW_NONE) && (w_cand <= C_MAX_ID);

    w_used_cur = '0;
    for (int i = 1; i <= NUM_ROWS; i++) begin
      if (w_cand == ROW_ID_W'(i)) w_used_cur = r_used[i];
    end

    // 6-bit sum so a full row plus a wide request cannot wrap into a "fit".
    w_sum  = {1'b0, w_used_cur} + {1'b0, r_req.width};
    w_fits = (w_sum <= C_ROW_WIDTH);

    w_clr_hit = io.clr_valid && (io.clr_row != ROW_NONE) && (io.clr_row <= C_MAX_ID);
    w_probe   = (r_state == S_CHECK);
    // A clear on the row being probed wins; the probe repeats next cycle.
    w_stall   = w_probe && w_cand_valid && w_clr_hit && (io.clr_row == w_cand);
    w_grant   = w_probe && w_cand_valid && !w_stall && w_fits;
    w_fail    = (w_accept && w_width_bad) ||
                (w_probe && (!w_cand_valid ||
                             (!w_stall && !w_fits && (r_idx == 2'd2))));
    w_resp_done = (r_state == S_RESP) && io.resp_ready;

    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = w_width_bad ? S_RESP : S_CHECK;
      S_CHECK: if (w_grant || w_fail) w_next_state = S_RESP;
      S_RESP:  if (w_resp_done) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_req        <= '0;
      r_idx        <= '0;
      r_rsp        <= '0;
      r_resp_valid <= 1'b0;
      r_req_ready  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_req_ready <= (w_next_state == S_IDLE);
      r_busy      <= (w_next_state != S_IDLE);

      if (w_accept) begin
        r_req <= '{width: io.req_width, cand_1: io.cand_id_1,
                   cand_2: io.cand_id_2, cand_3: io.cand_id_3};
        r_idx <= '0;
      end else if (w_probe && w_cand_valid && !w_stall && !w_fits && (r_idx != 2'd2)) begin
        r_idx <= r_idx + 2'd1;
      end

      if (w_grant) begin
        r_resp_valid <= 1'b1;
        r_rsp        <= '{ok: 1'b1, row: w_cand, x: w_used_cur};
      end else if (w_fail) begin
        r_resp_valid <= 1'b1;
        r_rsp        <= '0;
      end else if (w_resp_done) begin
        r_resp_valid <= 1'b0;
        r_rsp        <= '0;
      end
    end
  end

  // Occupancy bump pointers; clear and grant never target the same row
  // in one cycle because that case stalls the probe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= NUM_ROWS; i++) r_used[i] <= '0;
    end else begin
      for (int i = 1; i <= NUM_ROWS; i++) begin
        if (w_clr_hit && (io.clr_row == ROW_ID_W'(i))) begin
          r_used[i] <= '0;
        end else if (w_grant && (w_cand == ROW_ID_W'(i))) begin
          r_used[i] <= w_sum[COL_W-1:0];
        end
      end
    end
  end

  assign io.req_ready  = r_req_ready;
  assign io.resp_valid = r_resp_valid;
  assign io.resp_ok    = r_rsp.ok;
  assign io.resp_row   = r_rsp.row;
  assign io.resp_x     = r_rsp.x;
  assign io.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_row_allocator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_row_allocator                                            |
// | Directed self-checking bench for row_allocator.                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_row_allocator;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  row_allocator_if bus ();

  row_allocator #(.NUM_ROWS(13), .ROW_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request (optionally with a one-cycle clear right after the
  // accept) and return cycles from the accept edge until resp_valid.
  task automatic do_req(input logic [4:0] w, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic clr_en, input logic [3:0] clr_id,
                        output int lat);
    bus.req_valid = 1'b1;
    bus.req_width = w;
    bus.cand_id_1 = a;
    bus.cand_id_2 = b;
    bus.cand_id_3 = c;
    tick();
    bus.req_valid = 1'b0;
    if (clr_en) begin
      bus.clr_valid = 1'b1;
      bus.clr_row   = clr_id;
    end
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      tick();
      bus.clr_valid = 1'b0;
      lat++;
    end
    bus.clr_valid = 1'b0;
    chk("resp_timeout", 32'(lat < 20), 32'd1);
  endtask

  task automatic ack();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input int lat, input int exp_lat,
                             input logic ok, input logic [3:0] row, input logic [4:0] x);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_ok"},  32'(bus.resp_ok), 32'(ok));
    chk({tag, "_row"}, 32'(bus.resp_row), 32'(row));
    chk({tag, "_x"},   32'(bus.resp_x), 32'(x));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  32'(bus.req_ready), 32'd0);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_resp_ok"},    32'(bus.resp_ok), 32'd0);
    chk({tag, "_resp_row"},   32'(bus.resp_row), 32'd0);
    chk({tag, "_resp_x"},     32'(bus.resp_x), 32'd0);
    chk({tag, "_busy"},       32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    n_checks = 0;
    n_errors = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_width  = '0;
    bus.cand_id_1  = '0;
    bus.cand_id_2  = '0;
    bus.cand_id_3  = '0;
    bus.resp_ready = 1'b0;
    bus.clr_valid  = 1'b0;
    bus.clr_row    = '0;

    // Reset state
    tick();
    tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);

    // Basic grant and bump
    do_req(5'd6, 4'd10, 4'd8, 4'd0, 1'b0, 4'd0, lat);
    expect_resp("basic1", lat, 2, 1'b1, 4'd10, 5'd0);
    chk("basic1_busy", 32'(bus.busy), 32'd1);
    chk("basic1_req_ready", 32'(bus.req_ready), 32'd0);
    ack();
    chk("after_ack_req_ready", 32'(bus.req_ready), 32'd1);
    chk("after_ack_resp_valid", 32'(bus.resp_valid), 32'd0);
    do_req(5'd6, 4'd10, 4'd8, 4'd0, 1'b0, 4'd0, lat);
    expect_resp("basic2", lat, 2, 1'b1, 4'd10, 5'd6);
    ack();

    // Fallthrough: row 10 holds 12, 12+6 > 16
    do_req(5'd6, 4'd10, 4'd8, 4'd0, 1'b0, 4'd0, lat);
    expect_resp("fall", lat, 3, 1'b1, 4'd8, 5'd0);
    ack();

    // Exhaustion: row 9 at 1, width 16 misses, next candidate is 0
    do_req(5'd1, 4'd9, 4'd0, 4'd0, 1'b0, 4'd0, lat);
    expect_resp("fill9", lat, 2, 1'b1, 4'd9, 5'd0);
    ack();
    do_req(5'd16, 4'd9, 4'd0, 4'd0, 1'b0, 4'd0, lat);
    expect_resp("exhaust", lat, 3, 1'b0, 4'd0, 5'd0);
    chk("exhaust_valid", 32'(bus.resp_valid), 32'd1);
    ack();
    do_req(5'd0, 4'd1, 4'd2, 4'd3, 1'b0, 4'd0, lat);
    expect_resp("width0", lat, 1, 1'b0, 4'd0, 5'd0);
    ack();
    do_req(5'd17, 4'd1, 4'd2, 4'd3, 1'b0, 4'd0, lat);
    expect_resp("width17", lat, 1, 1'b0, 4'd0, 5'd0);
    ack();

    // Exact fill boundary on row 13
    do_req(5'd10, 4'd13, 4'd0, 4'd0, 1'b0, 4'd0, lat);
    expect_resp("fill13", lat, 2, 1'b1, 4'd13, 5'd0);
    ack();
    do_req(5'd6, 4'd13, 4'd12, 4'd11, 1'b0, 4'd0, lat);
    expect_resp("exact", lat, 2, 1'b1, 4'd13, 5'd10);
    ack();
    do_req(5'd1, 4'd13, 4'd12, 4'd11, 1'b0, 4'd0, lat);
    expect_resp("after_full", lat, 3, 1'b1, 4'd12, 5'd0);
    ack();

    // Clear/probe collision on full row 13: one stall, then grant at 0
    do_req(5'd4, 4'd13, 4'd0, 4'd0, 1'b1, 4'd13, lat);
    expect_resp("collide", lat, 3, 1'b1, 4'd13, 5'd0);
    ack();

    // Clear of a different row runs in parallel (row 12 held 1)
    do_req(5'd2, 4'd13, 4'd0, 4'd0, 1'b1, 4'd12, lat);
    expect_resp("par_clr", lat, 2, 1'b1, 4'd13, 5'd4);
    ack();
    do_req(5'd1, 4'd12, 4'd0, 4'd0, 1'b0, 4'd0, lat);
    expect_resp("par_clr_chk", lat, 2, 1'b1, 4'd12, 5'd0);
    ack();

    // Backpressure: row 8 holds 6
    do_req(5'd3, 4'd8, 4'd0, 4'd0, 1'b0, 4'd0, lat);
    expect_resp("bp", lat, 2, 1'b1, 4'd8, 5'd6);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_ok", 32'(bus.resp_ok), 32'd1);
      chk("bp_row", 32'(bus.resp_row), 32'd8);
      chk("bp_x", 32'(bus.resp_x), 32'd6);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    ack();

    // Reset during CHECK discards the request and clears occupancy
    bus.req_valid = 1'b1;
    bus.req_width = 5'd5;
    bus.cand_id_1 = 4'd10;
    bus.cand_id_2 = 4'd0;
    bus.cand_id_3 = 4'd0;
    tick();
    bus.req_valid = 1'b0;
    chk("midrst_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    do_req(5'd16, 4'd10, 4'd0, 4'd0, 1'b0, 4'd0, lat);
    expect_resp("rst_row10", lat, 2, 1'b1, 4'd10, 5'd0);
    ack();
    do_req(5'd16, 4'd8, 4'd0, 4'd0, 1'b0, 4'd0, lat);
    expect_resp("rst_row8", lat, 2, 1'b1, 4'd8, 5'd0);
    ack();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
